instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 151 +++++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words, launches one of four sub-FSMs and waits for its done.
// Optional watchdog on WAIT enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  fsm_start,
  input  logic [3:0]  fsm_done,
  output logic [5:0]  param1,
  output logic [5:0]  param2,
  output logic        busy,
  output logic        illegal,
  output logic        halted,
  output logic        timeout,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_HALT
  } state_e;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  p1_q, p1_d;
  logic [5:0]  p2_q, p2_d;
  logic [15:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        done_hit;
  logic [3:0]  opcode_in;

  assign opcode_in = instr[15:12];
  assign done_hit  = fsm_done[op_q];

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       wdog_expire;

  // Fires during the last permitted WAIT cycle, so the abort lands on the same edge a done would.
  assign wdog_expire = (state_q == S_WAIT) && !done_hit && (wdog_q == WDOG_LAST);
  assign timeout     = wdog_expire;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          if (opcode_in < 4'd4) begin
            op_d    = opcode_in[1:0];
            p1_d    = instr[11:6];
            p2_d    = instr[5:0];
            state_d = S_START;
          end else if (opcode_in == 4'hF) begin
            state_d = S_HALT;
          end else begin
            illegal_d = 1'b1;
            state_d   = run ? S_FETCH : S_IDLE;
          end
        end else if (!run) begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
`ifdef SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_hit) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = run ? S_FETCH : S_IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wdog_expire) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
`ifdef SEQ_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign instr_ready = (state_q == S_FETCH);
  assign fsm_start   = (state_q == S_START) ? 4'(4'b0001 << op_q) : '0;
  assign busy        = (state_q == S_START) || (state_q == S_WAIT);
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign param1      = p1_q;
  assign param2      = p2_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboarded random bench for instr_sequencer; expected start pulses are queued at issue time
// and popped by an independent monitor whenever fsm_start is non-zero.
module tb_instr_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO_CYC = 10;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clock = 1'b0;
  logic        reset, run, instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  fsm_start, fsm_done;
  logic [5:0]  param1, param2;
  logic        busy, illegal, halted, timeout;
  logic [15:0] instr_count;

  instr_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset), .run(run), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .fsm_start(fsm_start), .fsm_done(fsm_done),
    .param1(param1), .param2(param2), .busy(busy), .illegal(illegal), .halted(halted),
    .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ill_pending = 0;
  int          to_seen = 0;
  logic [15:0] count_m = '0;
  logic [5:0]  last_p1 = '0;
  logic [5:0]  last_p2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the oldest outstanding legal instruction.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (fsm_start != 4'b0000) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected actual=%b required=none", fsm_start);
        end else begin
          e = sb.pop_front();
          if ({fsm_start, param1, param2, instr_count} !== e) begin
            errors++;
            $display("FAIL start_pulse actual=%h required=%h", {fsm_start, param1, param2, instr_count}, e);
          end
        end
      end
      if (illegal) begin
        checks++;
        if (ill_pending == 0) begin
          errors++;
          $display("FAIL illegal_unexpected actual=1 required=0");
        end else begin
          ill_pending--;
        end
      end
      if (timeout) to_seen++;
    end
  end

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr = '0; fsm_done = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_m = '0; last_p1 = '0; last_p2 = '0;
    sb.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 32'(0));
    chk({tag, "_start"}, 32'(fsm_start), 32'(0));
    chk({tag, "_params"}, 32'({param1, param2}), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_illegal"}, 32'(illegal), 32'(0));
    chk({tag, "_halted"}, 32'(halted), 32'(0));
    chk({tag, "_timeout"}, 32'(timeout), 32'(0));
    chk({tag, "_count"}, 32'(instr_count), 32'(0));
  endtask

  // Presents w until accepted; returns at the negedge of the cycle after the transfer edge.
  task automatic issue(input logic [15:0] w, output bit ok);
    logic [3:0] op;
    int         waited;
    op = w[15:12];
    if (op < 4'd4) begin
      sb.push_back({4'(4'b0001 << op), w[11:6], w[5:0], count_m});
      last_p1 = w[11:6];
      last_p2 = w[5:0];
    end else if (op != 4'hF) begin
      ill_pending++;
    end
    instr = w;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    ok = instr_ready;
    if (!ok) chk("ready_wait_bound", 32'(instr_ready), 32'(1));
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  // Called in the START cycle: checks the one-hot pulse, then returns the matching done.
  task automatic complete(input logic [1:0] op, input int delay, input bit drop_run);
    logic [3:0] oh;
    oh = 4'(4'b0001 << op);
    chk("start_latency", 32'(fsm_start), 32'(oh));
    chk("busy_in_start", 32'(busy), 32'(1));
    chk("ready_in_start", 32'(instr_ready), 32'(0));
    fsm_done = 4'($urandom) | oh;
    if (drop_run) run = 1'b0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clock);
      fsm_done = (d == 0) ? (4'hF & ~oh) : (4'($urandom) & ~oh);
    end
    @(negedge clock);
    chk("busy_in_wait", 32'(busy), 32'(1));
    fsm_done = oh;
    count_m = count_m + 16'd1;
    @(negedge clock);
    fsm_done = '0;
    chk("count_after_done", 32'(instr_count), 32'(count_m));
    chk("ready_after_done", 32'(instr_ready), 32'(!drop_run));
    chk("busy_after_done", 32'(busy), 32'(0));
  endtask

  initial begin
    bit          ok;
    logic [3:0]  op;
    logic [15:0] w;
    int          first_to;
    int          busy_cycles;

    do_reset();
    chk_zero_outputs("reset");

    // MOV p1=1 p2=2, done after 3 cycles
    run = 1'b1;
    issue(16'h0042, ok);
    chk("mov_param1", 32'(param1), 32'(1));
    chk("mov_param2", 32'(param2), 32'(2));
    complete(2'd0, 2, 1'b0);

    // ADD with foreign done bits asserted first
    issue(16'h1FFF, ok);
    complete(2'd1, 3, 1'b0);

    // Illegal opcode: pulse once, no start, nothing else moves
    issue(16'h5000, ok);
    chk("illegal_pulse", 32'(illegal), 32'(1));
    chk("illegal_no_start", 32'(fsm_start), 32'(0));
    @(negedge clock);
    chk("illegal_one_cycle", 32'(illegal), 32'(0));
    chk("illegal_count", 32'(instr_count), 32'(count_m));
    chk("illegal_params", 32'({param1, param2}), 32'({last_p1, last_p2}));
    chk("illegal_stays_fetch", 32'(instr_ready), 32'(1));

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 14));
      w = {op, 12'($urandom)};
      run = 1'b1;
      issue(w, ok);
      if (ok) begin
        if (op < 4'd4) begin
          complete(op[1:0], $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
        end else begin
          chk("rnd_illegal_pulse", 32'(illegal), 32'(1));
          @(negedge clock);
          chk("rnd_illegal_params", 32'({param1, param2}), 32'({last_p1, last_p2}));
          chk("rnd_illegal_count", 32'(instr_count), 32'(count_m));
        end
      end
    end

    // Build count to 7, then reset in the middle of WAIT with done asserted
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = 4'($urandom_range(0, 3));
      issue({op, 12'($urandom)}, ok);
      complete(op[1:0], $urandom_range(0, 3), 1'b0);
    end
    chk("count_seven", 32'(instr_count), 32'(7));
    issue(16'h2123, ok);
    @(negedge clock);
    reset = 1'b1;
    fsm_done = 4'b0100;
    @(negedge clock);
    reset = 1'b0;
    fsm_done = '0;
    count_m = '0; last_p1 = '0; last_p2 = '0;
    chk_zero_outputs("midwait_reset");
    @(negedge clock);
    chk("post_reset_no_start", 32'(fsm_start), 32'(0));
    chk("post_reset_count", 32'(instr_count), 32'(0));

    // Watchdog behaviour in WAIT without any done
    issue(16'h3041, ok);
    busy_cycles = 0;
    first_to = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
      if (timeout && first_to == 0) first_to = c;
    end
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_cycle", 32'(first_to), 32'(TO_CYC));
    chk("timeout_busy_cycles", 32'(busy_cycles), 32'(TO_CYC));
    chk("timeout_count", 32'(instr_count), 32'(count_m));
`else
    chk("wait_unbounded", 32'(busy_cycles), 32'(300));
    chk("no_timeout", 32'(first_to), 32'(0));
`endif
    do_reset();

    // HALT: sticky until reset, ignores further words
    run = 1'b1;
    issue(16'hF000, ok);
    chk("halted_set", 32'(halted), 32'(1));
    chk("halt_params", 32'({param1, param2}), 32'(0));
    instr = 16'h0042;
    instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clock);
    chk("halt_sticky", 32'(halted), 32'(1));
    chk("halt_ready", 32'({instr_ready, fsm_start, busy}), 32'(0));
    chk("halt_count", 32'(instr_count), 32'(0));
    do_reset();
    chk("halt_cleared", 32'(halted), 32'(0));

    @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    chk("illegal_all_seen", 32'(ill_pending), 32'(0));
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_pulses", 32'(to_seen), 32'(1));
`else
    chk("timeout_pulses", 32'(to_seen), 32'(0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_time_limit actual=expired required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
